// File: rtl/asrv32_clint.sv
// asrv32_clint: memory-mapped core-local interruptor.
// Holds the 64-bit mtime counter with its timebase prescaler, one 64-bit
// mtimecmp and one MSIP bit per hart, and drives the per-hart timer and
// software interrupt lines. Bus accesses use a simple req/ack handshake.
//
// Optional build macro: ASRV32_CLINT_RDSNAP_EN
//   When defined, a read of MTIME lo latches mtime[63:32] into a shadow
//   register, and a read of MTIME hi returns that shadow. This gives a
//   tear-free 64-bit read. When undefined, MTIME hi reads the live counter
//   and no shadow register exists.
//
// Register map (byte offsets, bits [1:0] ignored):
//   0x0000 + 4*h     MSIP[h]          (bit 0 only)
//   0x4000 + 8*h     MTIMECMP[h] lo
//   0x4004 + 8*h     MTIMECMP[h] hi
//   0xBFF8           MTIME lo
//   0xBFFC           MTIME hi
//   Anything else, and any h >= NUM_HARTS, reads 0 and ignores writes.

module asrv32_clint #(
  parameter int NUM_HARTS = 1,
  parameter int TICK_DIV  = 100
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req,
  input  logic                 i_we,
  input  logic [15:0]          i_addr,
  input  logic [31:0]          i_wdata,
  input  logic [3:0]           i_wstrb,
  output logic                 o_ack,
  output logic [31:0]          o_rdata,
  output logic [NUM_HARTS-1:0] o_msip,
  output logic [NUM_HARTS-1:0] o_mtip,
  output logic [63:0]          o_mtime
);

  // Prescaler width; a divider of 1 still gets a 1-bit counter that never
  // leaves 0, so every cycle is a tick.
  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

  // Word addresses (i_addr[15:2]) of the two mtime halves.
  localparam logic [13:0]     MTIME_LO_WORD = 14'h2FFE;
  localparam logic [13:0]     MTIME_HI_WORD = 14'h2FFF;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [63:0]          mtime_q, mtime_d;
  logic [63:0]          cmp_q [NUM_HARTS];
  logic [63:0]          cmp_d [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_q, msip_d;
  logic [NUM_HARTS-1:0] mtip_q, mtip_d;
  logic [31:0]          rdata_q, rdata_d;

  logic                 tick;
  logic                 accept;
  logic                 wr;
  logic                 rd;
  logic [13:0]          word;
  logic                 msip_sel;
  logic                 cmp_sel;
  logic                 cmp_hi;
  logic [11:0]          msip_idx;
  logic [10:0]          cmp_idx;
  logic                 mtime_lo_sel;
  logic                 mtime_hi_sel;
  logic [31:0]          mtime_hi_rd;

  // Byte-lane merge: each strobed byte takes the bus value, the rest keep old.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Address decode. Hart-range checks happen where the index is compared
  // against each implemented hart, so out-of-range harts simply match nothing.
  // ---------------------------------------------------------------------------
  assign word         = i_addr[15:2];
  assign accept       = (state_q == S_IDLE) && i_req;
  assign wr           = accept && i_we;
  assign rd           = accept && !i_we;
  assign msip_sel     = (i_addr[15:14] == 2'b00);
  assign msip_idx     = i_addr[13:2];
  assign cmp_sel      = (i_addr[15:14] == 2'b01);
  assign cmp_idx      = i_addr[13:3];
  assign cmp_hi       = i_addr[2];
  assign mtime_lo_sel = (word == MTIME_LO_WORD);
  assign mtime_hi_sel = (word == MTIME_HI_WORD);
  assign tick         = (presc_q == PRESC_MAX);

  // Byte offset bits are ignored by the word-aligned map.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, i_addr[1:0]};

  // Bus handshake: accept in IDLE, acknowledge for exactly one cycle in RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_req) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next-state for the timer, the register file and the read data.
  // NOTE: every target gets a default before any condition so no path leaves
  // it unassigned; that is what keeps this block free of latches.
  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    msip_d  = msip_q;
    rdata_d = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      cmp_d[h] = cmp_q[h];
    end

    if (wr) begin
      // A bus write to mtime replaces the addressed half and keeps the other
      // half at its current value, so a coincident tick adds nothing. The
      // prescaler still follows its own schedule, which on a tick is 0.
      if (mtime_lo_sel) begin
        mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], i_wdata, i_wstrb)};
      end
      if (mtime_hi_sel) begin
        mtime_d = {merge_bytes(mtime_q[63:32], i_wdata, i_wstrb), mtime_q[31:0]};
      end
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (msip_sel && (msip_idx == 12'(h)) && i_wstrb[0]) begin
          msip_d[h] = i_wdata[0];
        end
        if (cmp_sel && (cmp_idx == 11'(h))) begin
          if (cmp_hi) begin
            cmp_d[h][63:32] = merge_bytes(cmp_q[h][63:32], i_wdata, i_wstrb);
          end else begin
            cmp_d[h][31:0]  = merge_bytes(cmp_q[h][31:0], i_wdata, i_wstrb);
          end
        end
      end
    end

    if (rd) begin
      if (mtime_lo_sel) rdata_d = mtime_q[31:0];
      if (mtime_hi_sel) rdata_d = mtime_hi_rd;
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (msip_sel && (msip_idx == 12'(h))) begin
          rdata_d = {31'b0, msip_q[h]};
        end
        if (cmp_sel && (cmp_idx == 11'(h))) begin
          rdata_d = cmp_hi ? cmp_q[h][63:32] : cmp_q[h][31:0];
        end
      end
    end
  end

  // Timer compare on the current register values; the registered result
  // therefore shows any write one cycle after the write edge.
  always_comb begin
    mtip_d = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      mtip_d[h] = (mtime_q >= cmp_q[h]);
    end
  end

  // State registers. Compare registers reset to all-ones so no timer
  // interrupt fires before software programs them.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  // NOTE: the mtimecmp array is reset element by element; it is a handful of
  // flops, not a RAM, and a defined reset value is functionally required.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      mtime_q <= '0;
      msip_q  <= '0;
      mtip_q  <= '0;
      rdata_q <= '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        cmp_q[h] <= '1;
      end
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      mtime_q <= mtime_d;
      msip_q  <= msip_d;
      mtip_q  <= mtip_d;
      rdata_q <= rdata_d;
      for (int h = 0; h < NUM_HARTS; h++) begin
        cmp_q[h] <= cmp_d[h];
      end
    end
  end

`ifdef ASRV32_CLINT_RDSNAP_EN
  logic [31:0] shadow_q, shadow_d;

  // Shadow of mtime hi: captured by a lo read, overwritten by a hi write.
  always_comb begin
    shadow_d = shadow_q;
    if (rd && mtime_lo_sel) shadow_d = mtime_q[63:32];
    if (wr && mtime_hi_sel) shadow_d = mtime_d[63:32];
  end

  // Shadow register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) shadow_q <= '0;
    else          shadow_q <= shadow_d;
  end

  assign mtime_hi_rd = shadow_q;
`else
  assign mtime_hi_rd = mtime_q[63:32];
`endif

  assign o_ack   = (state_q == S_RESP);
  assign o_rdata = rdata_q;
  assign o_msip  = msip_q;
  assign o_mtip  = mtip_q;
  assign o_mtime = mtime_q;

endmodule
